// File: rtl/alram_rdstream.sv
// alram_rdstream: read sequencer + stream adapter for the 256b x 32 dual-port RAM.
// A start command issues a burst of read addresses, the fixed 2-cycle RAM read
// latency is tracked by a tag pipe, and returned words land in a small FIFO that
// feeds a valid/ready stream. Reads are only issued while the FIFO plus the words
// in flight leave room, so backpressure never drops a returned word.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start, base, len  burst request (honoured only when idle), first address, word count
//   busy, done        burst in progress, one-cycle completion pulse
//   ra, rdo           RAM read address (registered), RAM read data (2-cycle latency)
//   odat, ovld, olast stream data / valid / last-word marker
//   ordy              stream ready from the consumer
module alram_rdstream #(
  parameter int unsigned WID  = 256,
  parameter int unsigned AWID = 5,
  parameter int unsigned DEP  = 1 << AWID,
  parameter int unsigned FDEP = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [AWID-1:0] base,
  input  logic [AWID:0]   len,
  output logic            busy,
  output logic            done,
  output logic [AWID-1:0] ra,
  input  logic [WID-1:0]  rdo,
  output logic [WID-1:0]  odat,
  output logic            ovld,
  output logic            olast,
  input  logic            ordy
);

  localparam int unsigned LW = AWID + 1;           // burst length / issue counter width
  localparam int unsigned CW = $clog2(FDEP + 1);   // FIFO occupancy width
  localparam int unsigned IW = $clog2(FDEP);       // FIFO entry index width
  localparam int unsigned TW = CW + 1;             // credit arithmetic width

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_FIN} state_t;

  state_t          state;
  logic [LW-1:0]   len_q;
  logic [LW-1:0]   icnt;          // reads issued so far in this burst
  logic [2:0]      pv;            // in-flight valid tags: [0]=issue, [1]=s1, [2]=s2
  logic [2:0]      pl;            // matching last-word tags
  logic [WID:0]    q [FDEP];      // shift FIFO, entry 0 is the head; bit WID = last
  logic [CW-1:0]   cnt;

  logic            pop_c;
  logic            push_c;
  logic [TW-1:0]   inflight_c;
  logic            credit_c;
  logic [LW-1:0]   icnt_inc_c;
  logic            issue_c;
  logic            issue_last_c;
  logic [AWID-1:0] ra_nxt_c;
  logic [CW-1:0]   cnt_nxt_c;
  logic [IW-1:0]   widx_c;
  logic            head_last_c;

  assign odat = q[0][WID-1:0];

  // Issue decision, credit check and FIFO bookkeeping for the coming edge.
  always_comb begin
    pop_c        = ovld & ordy;
    push_c       = pv[2];
    inflight_c   = TW'(pv[0]) + TW'(pv[1]) + TW'(pv[2]);
    // A pop this cycle frees a slot at the same edge the new read enters the pipe.
    credit_c     = (TW'(cnt) + inflight_c - TW'(pop_c)) < TW'(FDEP);
    icnt_inc_c   = icnt + LW'(1);
    issue_c      = 1'b0;
    issue_last_c = 1'b0;
    ra_nxt_c     = ra;
    case (state)
      S_IDLE: begin
        if (start && (len != '0)) begin
          issue_c      = 1'b1;
          issue_last_c = (len == LW'(1));
          ra_nxt_c     = base;
        end
      end
      S_ISSUE: begin
        if (credit_c) begin
          issue_c      = 1'b1;
          issue_last_c = (icnt_inc_c == len_q);
          ra_nxt_c     = AWID'((int'(ra) + 1) % int'(DEP));
        end
      end
      default: ;
    endcase
    cnt_nxt_c = cnt + CW'(push_c) - CW'(pop_c);
    widx_c    = pop_c ? IW'(cnt - CW'(1)) : IW'(cnt);
    // Last flag of the entry that will sit at the head after this edge.
    if (pop_c) head_last_c = (cnt > CW'(1)) ? q[1][WID] : pl[2];
    else       head_last_c = (cnt == '0)    ? pl[2]     : q[0][WID];
  end

  // FSM, address issue, tag pipe and output FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      ra    <= '0;
      ovld  <= 1'b0;
      olast <= 1'b0;
      cnt   <= '0;
      pv    <= '0;
      pl    <= '0;
      len_q <= '0;
      icnt  <= '0;
      for (int unsigned i = 0; i < FDEP; i++) q[IW'(i)] <= '0;
    end else begin
      pv    <= {pv[1:0], issue_c};
      pl    <= {pl[1:0], issue_c & issue_last_c};
      if (issue_c) ra <= ra_nxt_c;

      cnt   <= cnt_nxt_c;
      ovld  <= (cnt_nxt_c != '0);
      olast <= (cnt_nxt_c != '0) & head_last_c;
      if (pop_c) begin
        for (int unsigned i = 0; i < FDEP - 1; i++) q[IW'(i)] <= q[IW'(i + 1)];
      end
      if (push_c) q[widx_c] <= {pl[2], rdo};

      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            len_q <= len;
            if (len == '0) begin
              state <= S_FIN;
              done  <= 1'b1;
            end else begin
              state <= (len == LW'(1)) ? S_DRAIN : S_ISSUE;
              busy  <= 1'b1;
              icnt  <= LW'(1);
            end
          end
        end
        S_ISSUE: begin
          if (issue_c) begin
            icnt <= icnt_inc_c;
            if (issue_last_c) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (pop_c && olast) begin
            state <= S_FIN;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        S_FIN: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alram_rdstream.sv
// Directed bench for alram_rdstream with a behavioural 2-cycle-latency RAM model.
module tb_alram_rdstream;

  localparam int unsigned WID  = 256;
  localparam int unsigned AWID = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [AWID-1:0] base;
  logic [AWID:0]   len;
  logic            busy, done, ovld, olast, ordy;
  logic [AWID-1:0] ra;
  logic [WID-1:0]  rdo, r1, odat;
  logic [WID-1:0]  mem [32];

  int nvec = 0;
  int nerr = 0;

  alram_rdstream dut (
    .clk(clk), .rst(rst), .start(start), .base(base), .len(len),
    .busy(busy), .done(done), .ra(ra), .rdo(rdo),
    .odat(odat), .ovld(ovld), .olast(olast), .ordy(ordy)
  );

  always #5 clk = ~clk;

  // RAM read port: address sampled at the edge, data visible two cycles later.
  always @(posedge clk) begin
    r1  <= mem[ra];
    rdo <= r1;
  end

  function automatic logic [WID-1:0] mw(input int i);
    mw = {32'(i) ^ 32'hA5A5_0000, 192'd0, 32'(i)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chkw(input string tag, input logic [WID-1:0] obs, input logic [WID-1:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // mode 0: ordy=1 with exact timing checks; 1: ordy low for cycles 0-15; 2: random ordy.
  // restart: extra start pulses while busy and during FIN, which must be ignored.
  task automatic run_burst(input int bi, input int li, input int mode, input bit restart);
    int cyc, nw, ndone, nlast, ra0;
    bit fin, prev_stall;
    logic [WID-1:0] prev_d;
    logic prev_l;
    ra0 = int'(ra);
    nw = 0; ndone = 0; nlast = 0; fin = 1'b0; prev_stall = 1'b0; cyc = 0;
    prev_d = '0; prev_l = 1'b0;
    base  = AWID'(bi);
    len   = (AWID + 1)'(li);
    start = 1'b1;
    ordy  = (mode == 0) ? 1'b1 : (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
    while (!fin && cyc < 200) begin
      tick();
      cyc++;
      start = 1'b0;
      if (restart && cyc == 2) begin
        base  = AWID'(bi + 9);
        len   = 6'd5;
        start = 1'b1;
      end
      case (mode)
        0:       ordy = 1'b1;
        1:       ordy = (cyc >= 16);
        default: ordy = 1'($urandom_range(0, 1));
      endcase
      if (prev_stall) begin
        chkw("hold_dat", odat, prev_d);
        chki("hold_last", int'(olast), int'(prev_l));
        chki("hold_vld", int'(ovld), 1);
      end
      if (mode == 0) begin
        chki("busy", int'(busy), (li != 0 && cyc < li + 4) ? 1 : 0);
        chki("ovld", int'(ovld), (li != 0 && cyc >= 4 && cyc <= li + 3) ? 1 : 0);
        if (cyc <= li) chki("ra", int'(ra), (bi + cyc - 1) % 32);
      end
      if (mode == 1 && cyc == 15) begin
        chki("bp_ra", int'(ra), (bi + 3) % 32);
        chki("bp_vld", int'(ovld), 1);
      end
      if (!ovld) chki("olast_idle", int'(olast), 0);
      if (ovld && ordy) begin
        chkw("odat", odat, mw((bi + nw) % 32));
        chki("olast", int'(olast), (nw == li - 1) ? 1 : 0);
        if (olast) nlast++;
        nw++;
      end
      prev_stall = ovld && !ordy;
      prev_d     = odat;
      prev_l     = olast;
      if (done) begin
        ndone++;
        fin = 1'b1;
        if (mode == 0) chki("done_cyc", cyc, (li == 0) ? 1 : li + 4);
        if (restart) begin
          base  = AWID'(bi + 3);
          len   = 6'd5;
          start = 1'b1;
        end
      end
    end
    chki("finished", int'(fin), 1);
    chki("nwords", nw, li);
    chki("nlast", nlast, (li != 0) ? 1 : 0);
    ordy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      start = 1'b0;
      if (done) ndone++;
      if (ovld) nw++;
      chki("busy_tail", int'(busy), 0);
    end
    chki("ndone", ndone, 1);
    chki("nwords_tail", nw, li);
    if (li == 0) chki("ra_hold", int'(ra), ra0);
    if (restart) chki("ra_after", int'(ra), (bi + li - 1) % 32);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = mw(i);
    rst = 1'b1; start = 1'b0; base = '0; len = '0; ordy = 1'b0;
    tick(); tick();
    chki("rst_busy", int'(busy), 0);
    chki("rst_done", int'(done), 0);
    chki("rst_ra", int'(ra), 0);
    chki("rst_ovld", int'(ovld), 0);
    chki("rst_olast", int'(olast), 0);
    rst = 1'b0;
    tick();

    run_burst(0, 4, 0, 1'b0);     // basic burst
    run_burst(30, 4, 0, 1'b0);    // address wrap 30,31,0,1
    run_burst(20, 12, 0, 1'b0);   // sustained one word per cycle
    run_burst(9, 1, 0, 1'b0);     // single word
    run_burst(0, 8, 1, 1'b0);     // backpressure, credit limit
    run_burst(7, 32, 2, 1'b0);    // full RAM sweep with random ready
    run_burst(11, 0, 0, 1'b0);    // empty burst
    run_burst(10, 3, 0, 1'b1);    // starts while busy and in FIN ignored

    // Reset in cycle 3 of a len=8 burst; stale RAM returns must be dropped.
    base = 5'd0; len = 6'd8; ordy = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chki("mrst_busy", int'(busy), 0);
    chki("mrst_ovld", int'(ovld), 0);
    chki("mrst_done", int'(done), 0);
    chki("mrst_ra", int'(ra), 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chki("mrst_quiet", int'(ovld | done | busy), 0);
    end
    run_burst(5, 2, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
